div_unit: RTL and testbench

- Multi-cycle 32-bit integer divider for DIV/DIVU, located in the execute stage.
- It is the responder to the pipeline control path. It receives a start request while a divide instruction sits in E, and drives the division stall that holds E and earlier stages; that stall is carried into M as stall_divM.
- When it finishes, it pulses ready with the quotient/remainder pair, which is written to HI/LO downstream.

---
 rtl/cpu_defs_pkg.sv | 14 +
 rtl/div_step.sv | 23 ++
 rtl/div_unit.sv | 130 +++++++++++++
 tb/tb_div_unit.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: divider width, state encoding and the divide-by-zero result.
package cpu_defs_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  localparam logic [2*DIV_WIDTH-1:0] DIV_ZERO_RESULT = '0;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract the divisor if it fits.
module div_step
  import cpu_defs_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dvd_bit,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] trial;

  // W+1-bit trial keeps the shifted-out remainder MSB, so the compare cannot overflow
  always_comb begin
    trial    = {rem, dvd_bit};
    q_bit    = (trial >= {1'b0, divisor});
    rem_next = q_bit ? WIDTH'(trial - {1'b0, divisor}) : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit for the execute stage; stalls the pipeline until the result pulses out.
module div_unit
  import cpu_defs_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  input  logic               annul,
  output logic               stall_div,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               ready_q, ready_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0]   rem_nx;
  logic [WIDTH-1:0]   quo_nx;
  logic               q_bit;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH-1:0]   rem_fix, quo_fix;

  // quo_q starts as the dividend; its MSB feeds the step while quotient bits enter at the LSB
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem_q),
    .divisor (dvs_q),
    .dvd_bit (quo_q[WIDTH-1]),
    .rem_next(rem_nx),
    .q_bit   (q_bit)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    ready_d  = 1'b0;
    result_d = result_q;

    quo_nx  = {quo_q[WIDTH-2:0], q_bit};
    rem_fix = rneg_q ? -rem_nx : rem_nx;
    quo_fix = qneg_q ? -quo_nx : quo_nx;
    abs_a   = (signed_div && opa[WIDTH-1]) ? -opa : opa;
    abs_b   = (signed_div && opb[WIDTH-1]) ? -opb : opb;

    unique case (state_q)
      DIV_IDLE: begin
        if (start && !annul) begin
          quo_d  = abs_a;
          dvs_d  = abs_b;
          qneg_d = signed_div & (opa[WIDTH-1] ^ opb[WIDTH-1]);
          rneg_d = signed_div & opa[WIDTH-1];
          rem_d  = '0;
          cnt_d  = '0;
          if (opb == '0) begin
            state_d  = DIV_DONE;
            ready_d  = 1'b1;
            result_d = (2*WIDTH)'(DIV_ZERO_RESULT);
          end else begin
            state_d = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = DIV_DONE;
          ready_d  = 1'b1;
          result_d = {rem_fix, quo_fix};
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase

    // a flush cancels everything, including an imminent completion
    if (annul) begin
      state_d  = DIV_IDLE;
      ready_d  = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  assign stall_div = start & ~ready_q & ~annul;
  assign ready     = ready_q;
  assign result    = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed and random checks of div_unit against a queued reference of results and latencies.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] opa, opb;
  logic        annul;
  logic        stall_div;
  logic        ready;
  logic [63:0] result;

  int vectors = 0;
  int errors  = 0;
  int cyc_cnt = 0;
  logic [63:0] last_result = '0;
  logic [63:0] exp_q[$];
  int          lat_q[$];

  div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_div(signed_div),
    .opa       (opa),
    .opb       (opb),
    .annul     (annul),
    .stall_div (stall_div),
    .ready     (ready),
    .result    (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
    int     ia, ib;
    longint la, lb, q, r;
    if (b == 32'd0) return 64'd0;
    if (!sd) return {a % b, a / b};
    ia = a; ib = b;
    la = ia; lb = ib;
    q = la / lb;
    r = la % lb;
    return {r[31:0], q[31:0]};
  endfunction

  // Drives one divide from the current cycle (cycle 0) and waits for its result.
  task automatic issue(input logic sd, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] expres, input int explat, input bit hold,
                       input string tag, output int ready_at);
    bit got = 1'b0;
    bit stall_bad = 1'b0;
    logic [63:0] er;
    int el;
    signed_div = sd; opa = a; opb = b; start = 1'b1; annul = 1'b0;
    exp_q.push_back(expres);
    lat_q.push_back(explat);
    ready_at = -1;
    for (int c = 0; c <= explat + 3 && !got; c++) begin
      #1;
      if (ready === 1'b1) begin
        got = 1'b1;
        er = exp_q.pop_front();
        el = lat_q.pop_front();
        chk({tag, "_result"}, result, er);
        chk({tag, "_latency"}, 64'(c), 64'(el));
        chk({tag, "_stall_done"}, 64'(stall_div), 64'd0);
        last_result = result;
        ready_at = cyc_cnt;
      end else if (stall_div !== 1'b1) begin
        stall_bad = 1'b1;
      end
      @(posedge clk); #1;
      if (got && !hold) start = 1'b0;
    end
    chk({tag, "_stall_busy"}, 64'(stall_bad), 64'd0);
    if (!got) begin
      chk({tag, "_timeout"}, 64'(got), 64'd1);
      exp_q.delete();
      lat_q.delete();
      start = 1'b0;
    end
  endtask

  initial begin
    int r1, r2, rd;
    logic [31:0] ra, rb;
    logic rs;
    rst = 1'b0; start = 1'b0; signed_div = 1'b0; opa = '0; opb = '0; annul = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_result", result, 64'd0);
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_stall", 64'(stall_div), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    issue(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1'b0, "divu_100_7", rd);
    issue(1'b1, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 1'b0, "div_m7_2", rd);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33, 1'b0, "div_ovf", rd);
    issue(1'b0, 32'd5, 32'd0, 64'd0, 1, 1'b0, "divu_5_0", rd);
    issue(1'b0, 32'd17, 32'd5, {32'd2, 32'd3}, 33, 1'b0, "divu_17_5", rd);

    // annulled divide: no result, then an immediate new request must start cleanly
    signed_div = 1'b0; opa = 32'hFFFF_FFFF; opb = 32'd1; start = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    annul = 1'b1;
    #1;
    chk("annul_stall", 64'(stall_div), 64'd0);
    @(posedge clk); #1;
    annul = 1'b0;
    chk("annul_ready", 64'(ready), 64'd0);
    chk("annul_result_kept", result, last_result);
    issue(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 1'b0, "divu_9_3", rd);

    issue(1'b0, 32'd10, 32'd3, {32'd1, 32'd3}, 33, 1'b1, "b2b_a", r1);
    issue(1'b0, 32'd20, 32'd6, {32'd2, 32'd3}, 33, 1'b0, "b2b_b", r2);
    chk("b2b_gap", 64'(r2 - r1), 64'd34);

    // asynchronous reset in the middle of a divide
    signed_div = 1'b0; opa = 32'd100; opb = 32'd7; start = 1'b1;
    repeat (15) begin @(posedge clk); #1; end
    #2;
    rst = 1'b0; start = 1'b0;
    #1;
    chk("midrst_result", result, 64'd0);
    chk("midrst_ready", 64'(ready), 64'd0);
    chk("midrst_stall", 64'(stall_div), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    issue(1'b0, 32'd8, 32'd2, {32'd0, 32'd4}, 33, 1'b0, "divu_8_2", rd);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom_range(1, 5000);
      if (i % 3 == 1) rb = -rb;
      rs = (i % 2 == 1);
      issue(rs, ra, rb, model(rs, ra, rb), 33, 1'b0, "rand", rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
